// File: rtl/vedic_seq_divider_if.sv
// Operand/result handshake bundle for vedic_seq_divider.
// master = requester side, slave = divider side.
interface vedic_seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/vedic_seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, one operation in flight.
// Define VEDIC_DIV_SIGNED_EN for two's-complement operands (truncating division); default is unsigned.
module vedic_seq_divider #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    vedic_seq_divider_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             in_ready_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic             accept;
    logic             zero_div;
    logic             last_iter;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] sr_nx;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

`ifdef VEDIC_DIV_SIGNED_EN
    logic q_neg_q, r_neg_q;
    logic q_neg_d, r_neg_d;
`endif

    assign zero_div = (bus.divisor == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: registers take <= so every flop samples the pre-edge values of its peers.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_ready_q && bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == CNT_W'(1)) begin
                    last_iter = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The core only ever sees magnitudes; signs are reapplied when the result is loaded.
    always_comb begin
`ifdef VEDIC_DIV_SIGNED_EN
        q_neg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
        r_neg_d = bus.dividend[WIDTH-1];
        dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
`else
        dvd_mag = bus.dividend;
        dvs_mag = bus.divisor;
`endif
    end

    // The stored remainder is always below the divisor, so the top bit of the
    // (WIDTH+1)-bit partial remainder is only ever populated by the shift.
    always_comb begin
        rem_sh = {rem_q, sr_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            rem_nx = trial[WIDTH-1:0];
            sr_nx  = {sr_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[WIDTH-1:0];
            sr_nx  = {sr_q[WIDTH-2:0], 1'b0};
        end
    end

`ifdef VEDIC_DIV_SIGNED_EN
    assign q_final = q_neg_q ? -sr_nx  : sr_nx;
    assign r_final = r_neg_q ? -rem_nx : rem_nx;
`else
    assign q_final = sr_nx;
    assign r_final = rem_nx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b0;
            rem_q       <= '0;
            sr_q        <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef VEDIC_DIV_SIGNED_EN
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
`endif
        end else begin
            // Registered so ready stays low through reset and reopens only the cycle after consumption.
            in_ready_q <= (state_d == IDLE);

            if (accept) begin
                rem_q <= '0;
                sr_q  <= dvd_mag;
                dvs_q <= dvs_mag;
`ifdef VEDIC_DIV_SIGNED_EN
                q_neg_q <= q_neg_d;
                r_neg_q <= r_neg_d;
`endif
                if (zero_div) begin
                    quotient_q  <= '1;
                    remainder_q <= bus.dividend;
                    dbz_q       <= 1'b1;
                end else begin
                    cnt_q <= CNT_W'(WIDTH);
                end
            end else if (state_q == CALC) begin
                rem_q <= rem_nx;
                sr_q  <= sr_nx;
                cnt_q <= cnt_q - CNT_W'(1);
                if (last_iter) begin
                    quotient_q  <= q_final;
                    remainder_q <= r_final;
                    dbz_q       <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_vedic_seq_divider.sv
// Self-checking bench for vedic_seq_divider (WIDTH=8): arithmetic reference model plus
// directed vectors with hand-computed results; honours VEDIC_DIV_SIGNED_EN.
`timescale 1ns/1ps
module tb_vedic_seq_divider;
    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 1;   // edges counted from the accepting edge inclusive
    typedef logic [WIDTH-1:0] word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vedic_seq_divider_if #(.WIDTH(WIDTH)) bus ();
    vedic_seq_divider #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: plain division; divide-by-zero gives all ones and the dividend back.
    function automatic void model(input word_t a, input word_t b,
                                  output word_t q, output word_t r, output logic z);
        longint sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef VEDIC_DIV_SIGNED_EN
            sa = longint'($signed(a));
            sb = longint'($signed(b));
`else
            sa = longint'(a);
            sb = longint'(b);
`endif
            q = word_t'(sa / sb);
            r = word_t'(sa % sb);
            z = 1'b0;
        end
    endfunction

    // Expectation of the operation in flight, written by the driver only.
    int    pushed = 0;
    int    e_acc, e_lat, e_stall;
    word_t e_dvd, e_dvs, e_q, e_r;
    logic  e_z;

    // Observations, written by the compare process only.
    int    popped = 0;
    int    rise_n = 0;
    int    stalled = 0;
    int    last_consume_edge = -1;
    bit    seen_valid = 0;
    bit    post_consume = 0;
    word_t cap_q, cap_r;
    logic  cap_z;

    always @(negedge clk) begin : cmp
        int     n;
        word_t  recon;
        longint ar, ad;
        if (!rst_n) begin
            popped        = pushed;
            seen_valid    = 0;
            stalled       = 0;
            post_consume  = 0;
            bus.out_ready = 1'b1;
        end else begin
            if (post_consume) begin
                check("in_ready_after_consume", bus.in_ready, 1);
                post_consume = 0;
            end
            if (popped == pushed) begin
                check("idle_out_valid", bus.out_valid, 0);
                bus.out_ready = 1'b1;
            end else begin
                n = edge_cnt - e_acc + 1;
                bus.out_ready = (stalled >= e_stall);
                if (n >= 1) begin
                    check("in_ready_busy", bus.in_ready, 0);
                    check("out_valid_timing", bus.out_valid, (n >= e_lat));
                    if (bus.out_valid) begin
                        if (!seen_valid) begin
                            rise_n     = n;
                            seen_valid = 1;
                        end
                        check("quotient", bus.quotient, e_q);
                        check("remainder", bus.remainder, e_r);
                        check("div_by_zero", bus.div_by_zero, e_z);
                        if (stalled < e_stall) begin
                            stalled++;
                            bus.out_ready = 1'b0;
                        end else begin
                            cap_q = bus.quotient;
                            cap_r = bus.remainder;
                            cap_z = bus.div_by_zero;
                            if (e_dvs != '0) begin
                                recon = word_t'(bus.quotient * e_dvs + bus.remainder);
                                check("identity", recon, e_dvd);
`ifdef VEDIC_DIV_SIGNED_EN
                                ar = longint'($signed(bus.remainder));
                                ad = longint'($signed(e_dvs));
                                if (ar < 0) ar = -ar;
                                if (ad < 0) ad = -ad;
                                check("rem_bound", (ar < ad), 1);
`else
                                check("rem_bound", (bus.remainder < e_dvs), 1);
`endif
                            end
                            last_consume_edge = edge_cnt + 1;
                            popped++;
                            post_consume = 1;
                            seen_valid   = 0;
                            stalled      = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic do_op(input word_t a, input word_t b, input int stall);
        bit ok;
        ok = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        for (int g = 0; g < 60; g++) begin
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", bus.in_ready, 1);
            bus.in_valid = 1'b0;
        end else begin
            e_acc   = edge_cnt + 1;
            e_dvd   = a;
            e_dvs   = b;
            e_lat   = (b == '0) ? 1 : LAT;
            e_stall = stall;
            model(a, b, e_q, e_r, e_z);
            check("accept_after_consume", (e_acc > last_consume_edge), 1);
            pushed++;
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.dividend = ~a ^ 8'h5A;
            bus.divisor  = b + 8'd3;
        end
    endtask

    task automatic wait_done();
        for (int g = 0; g < 80; g++) begin
            if (popped == pushed) break;
            @(negedge clk);
        end
        check("result_timeout", popped, pushed);
    endtask

    task automatic expect_result(input string tag, input word_t q, input word_t r,
                                 input logic z, input int lat);
        check({tag, "_q"}, cap_q, q);
        check({tag, "_r"}, cap_r, r);
        check({tag, "_dbz"}, cap_z, z);
        check({tag, "_lat"}, rise_n, lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", bus.in_ready, 1);

`ifdef VEDIC_DIV_SIGNED_EN
        do_op(8'd200, 8'd7, 0);   wait_done(); expect_result("s_m56_7", 8'hF8, 8'h00, 1'b0, 9);
`else
        do_op(8'd200, 8'd7, 0);   wait_done(); expect_result("u_200_7", 8'd28, 8'd4, 1'b0, 9);
`endif
        do_op(8'd255, 8'd1, 0);
        do_op(8'd5, 8'd9, 0);
        expect_result("b2b_255_1", 8'd255, 8'd0, 1'b0, 9);
        wait_done();
        expect_result("b2b_5_9", 8'd0, 8'd5, 1'b0, 9);

        do_op(8'd100, 8'd0, 0);   wait_done(); expect_result("dbz_100_0", 8'hFF, 8'd100, 1'b1, 1);
        do_op(8'd9, 8'd3, 0);     wait_done(); expect_result("after_dbz_9_3", 8'd3, 8'd0, 1'b0, 9);
        do_op(8'd77, 8'd5, 6);    wait_done(); expect_result("stall_77_5", 8'd15, 8'd2, 1'b0, 9);

        // Abort mid-iteration: everything visible must drop at once, not at the next edge.
        do_op(8'd180, 8'd11, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_quotient", bus.quotient, 0);
        check("abort_remainder", bus.remainder, 0);
        check("abort_dbz", bus.div_by_zero, 0);
        check("abort_in_ready", bus.in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_abort", bus.in_ready, 1);
`ifdef VEDIC_DIV_SIGNED_EN
        do_op(8'd180, 8'd11, 0);  wait_done(); expect_result("s_m76_11", 8'hFA, 8'hF6, 1'b0, 9);
        do_op(8'hF9, 8'd2, 0);    wait_done(); expect_result("s_m7_2", 8'hFD, 8'hFF, 1'b0, 9);
        do_op(8'd7, 8'hFE, 1);    wait_done(); expect_result("s_7_m2", 8'hFD, 8'h01, 1'b0, 9);
        do_op(8'h80, 8'hFF, 0);   wait_done(); expect_result("s_m128_m1", 8'h80, 8'h00, 1'b0, 9);
        do_op(8'hF0, 8'h00, 0);   wait_done(); expect_result("s_dbz", 8'hFF, 8'hF0, 1'b1, 1);
`else
        do_op(8'd180, 8'd11, 0);  wait_done(); expect_result("u_180_11", 8'd16, 8'd4, 1'b0, 9);
        do_op(8'd255, 8'd255, 0); wait_done(); expect_result("u_255_255", 8'd1, 8'd0, 1'b0, 9);
        do_op(8'd3, 8'd200, 1);   wait_done(); expect_result("u_3_200", 8'd0, 8'd3, 1'b0, 9);
`endif

        for (int i = 0; i < 24; i++) begin
            word_t a, b;
            a = word_t'($urandom_range(0, 255));
            b = (i % 8 == 7) ? word_t'(0) : word_t'($urandom_range(1, 255));
            do_op(a, b, $urandom_range(0, 2));
        end
        wait_done();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vedic_seq_divider.md
Name: vedic_seq_divider

Overview:
- Iterative radix-2 restoring divider; the inverse operation of the Vedic multiplier tree. Recovers quotient and remainder from a product-domain operand.
- Takes a WIDTH-bit dividend and divisor through a valid/ready handshake.
- Produces the quotient and remainder after WIDTH iteration cycles.
- Sits beside the multiplier datapath for divide and modulo requests and for multiply/divide round-trip checking.

Parameters:
- WIDTH, 8, bit width of the dividend, divisor, quotient and remainder; legal values 2..64.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  dividend/divisor valid.
- in_ready  output  1  block can accept an operation.
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  WIDTH  dividend / divisor.
- remainder  output  WIDTH  dividend mod divisor.
- div_by_zero  output  1  result came from a zero divisor.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; in_ready=0 while rst_n is low and 1 from the first edge after release; out_valid=0; quotient=0; remainder=0; div_by_zero=0; counter=0; internal registers cleared.
- Reset asserted mid-operation aborts the operation immediately. No partial result is ever presented.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1.
  - On an edge with in_valid=1, the operands are captured.
  - divisor!=0: go to CALC; partial remainder (WIDTH+1 bits)=0; shift register=dividend; counter=WIDTH.
  - divisor==0: go directly to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
- CALC: in_ready=0. One iteration per cycle:
  - Shift {partial remainder, shift register} left by 1.
  - trial = partial remainder - {1'b0, divisor}.
  - If trial is non-negative, keep trial and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter decrements each cycle. On the edge where the counter goes 1->0, quotient and remainder are loaded, div_by_zero=0, and the FSM enters DONE.
- Latency: out_valid rises exactly WIDTH+1 edges after the accepting edge (9 for WIDTH=8). Divide-by-zero rises 1 edge after accept.
- DONE: out_valid=1, in_ready=0.
  - quotient, remainder and div_by_zero are held stable while out_ready=0 (no limit on stall length).
  - On an edge with out_ready=1: IDLE, out_valid=0.
  - in_ready returns the following cycle. A new operation is never accepted in the same cycle a result is consumed.
  - quotient, remainder and div_by_zero keep their last values after consumption until the next result loads.
- Operands are sampled only on the accepting edge. Changes on dividend/divisor at any other time have no effect.
- Arithmetic is unsigned by default. The following hold for every non-zero divisor:
  - quotient*divisor + remainder == dividend
  - remainder < divisor
- No throughput overlap: one operation in flight at a time.

Optional Feature:
- Macro: VEDIC_DIV_SIGNED_EN.
- Defined: operands and results are two's complement.
  - The magnitudes of both operands are taken at accept, and the unsigned core runs unchanged.
  - At the CALC->DONE load, quotient is negated if the operand signs differ, and remainder takes the sign of the dividend (truncation toward zero).
  - Most-negative / -1: quotient = most-negative (wraps), remainder = 0, div_by_zero = 0.
  - Divide-by-zero: quotient = all ones, remainder = dividend, as in unsigned mode.
  - Latency is unchanged.
- Undefined: purely unsigned; no sign logic is synthesised.

Test Plan:
- Parameter value for all scenarios: WIDTH=8.
- 200/7, out_ready=1 -> quotient=28, remainder=4, div_by_zero=0; out_valid 9 edges after accept; in_ready low from the accepting edge until the cycle after consumption.
- 255/1 then 5/9 back-to-back -> (255,0) then (0,5); the second accept occurs no earlier than the cycle after the first result is consumed.
- 100/0 -> after 1 edge: quotient=0xFF, remainder=100, div_by_zero=1; next op 9/3 -> (3,0) with div_by_zero=0.
- 77/5 with out_ready=0 for 6 cycles after out_valid -> quotient=15, remainder=2 stable throughout; in_ready=0; a single result consumed when out_ready=1.
- Accept 180/11, assert rst_n=0 at CALC cycle 4 -> out_valid, quotient and remainder go 0 immediately; after release, 180/11 -> (16,4) with normal latency.
- VEDIC_DIV_SIGNED_EN defined:
  - -7/2 -> quotient=0xFD, remainder=0xFF.
  - 7/-2 -> quotient=0xFD, remainder=0x01.
  - -128/-1 -> quotient=0x80, remainder=0.
  - Random unsigned sweep checked against quotient*divisor + remainder == dividend.
